ghost_mode_scheduler: RTL and testbench

- Sequences the ghost behaviour mode (scatter / chase / frightened) during active play.
- Sits beside the game-state FSM and is enabled by its playon output.
- Advances on a per-frame tick, pauses the scatter/chase schedule while ghosts are frightened, and counts ghosts eaten per power pellet for score multiplier selection.
- Outputs drive every ghost movement controller.

---
 rtl/ghost_mode_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_ghost_mode_scheduler.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ghost_mode_scheduler.sv
// Ghost behaviour mode sequencer: scatter/chase schedule, frightened override, eaten-ghost count.
// Optional macro FRIGHT_FLASH_EN enables the frightened sprite flash generator.
module ghost_mode_scheduler #(
   parameter int SCATTER_FRAMES = 420,
   parameter int CHASE_FRAMES   = 1200,
   parameter int FRIGHT_FRAMES  = 360,
   parameter int FLASH_FRAMES   = 120,
   parameter int NUM_PHASES     = 4
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic       playon,
   input  logic       frame_tick,
   input  logic       power_pellet,
   input  logic       ghost_eaten,
   output logic [1:0] mode,
   output logic       reverse_pulse,
   output logic       frightened_flash,
   output logic [1:0] eat_count,
   output logic [2:0] phase_idx
);

   // State encoding doubles as the mode output code.
   typedef enum logic [1:0] {
      ST_OFF     = 2'b00,
      ST_SCATTER = 2'b01,
      ST_CHASE   = 2'b10,
      ST_FRIGHT  = 2'b11
   } state_t;

   localparam logic [11:0] SCATTER_T = 12'(SCATTER_FRAMES);
   localparam logic [11:0] CHASE_T   = 12'(CHASE_FRAMES);
   localparam logic [11:0] FRIGHT_T  = 12'(FRIGHT_FRAMES);
   localparam logic [2:0]  LAST_IDX  = 3'(NUM_PHASES - 1);

   state_t      state_reg, state_next;
   state_t      saved_reg, saved_next;
   logic [11:0] phase_timer_reg, phase_timer_next;
   logic [11:0] fright_timer_reg, fright_timer_next;
   logic [2:0]  phase_idx_reg, phase_idx_next;
   logic [1:0]  eat_count_reg, eat_count_next;
   logic        reverse_reg, reverse_next;

   state_t      adv_state;
   logic [11:0] adv_timer;
   logic [2:0]  adv_idx;
   logic        period_end;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_reg        <= ST_OFF;
         saved_reg        <= ST_SCATTER;
         phase_timer_reg  <= '0;
         fright_timer_reg <= '0;
         phase_idx_reg    <= '0;
         eat_count_reg    <= '0;
         reverse_reg      <= 1'b0;
      end else begin
         state_reg        <= state_next;
         saved_reg        <= saved_next;
         phase_timer_reg  <= phase_timer_next;
         fright_timer_reg <= fright_timer_next;
         phase_idx_reg    <= phase_idx_next;
         eat_count_reg    <= eat_count_next;
         reverse_reg      <= reverse_next;
      end
   end

   // Outcome of a frame tick on the scatter/chase schedule; a zero timer means permanent chase.
   always_comb begin
      adv_state  = state_reg;
      adv_timer  = phase_timer_reg;
      adv_idx    = phase_idx_reg;
      period_end = 1'b0;
      if (frame_tick && phase_timer_reg == 12'd1) begin
         period_end = 1'b1;
         if (state_reg == ST_SCATTER) begin
            adv_state = ST_CHASE;
            adv_timer = CHASE_T;
         end else if (phase_idx_reg < LAST_IDX) begin
            adv_state = ST_SCATTER;
            adv_timer = SCATTER_T;
            adv_idx   = phase_idx_reg + 3'd1;
         end else begin
            adv_timer = 12'd0;
         end
      end else if (frame_tick && phase_timer_reg != 12'd0) begin
         adv_timer = phase_timer_reg - 12'd1;
      end
   end

   always_comb begin
      state_next        = state_reg;
      saved_next        = saved_reg;
      phase_timer_next  = phase_timer_reg;
      fright_timer_next = fright_timer_reg;
      phase_idx_next    = phase_idx_reg;
      eat_count_next    = eat_count_reg;
      reverse_next      = 1'b0;
      if (!playon) begin
         state_next        = ST_OFF;
         saved_next        = ST_SCATTER;
         phase_timer_next  = '0;
         fright_timer_next = '0;
         phase_idx_next    = '0;
         eat_count_next    = '0;
      end else begin
         unique case (state_reg)
            ST_OFF: begin
               state_next       = ST_SCATTER;
               phase_timer_next = SCATTER_T;
               phase_idx_next   = '0;
            end
            ST_SCATTER, ST_CHASE: begin
               if (power_pellet) begin
                  // A coincident tick only counts if it closes the period.
                  state_next        = ST_FRIGHT;
                  saved_next        = adv_state;
                  if (period_end) begin
                     phase_timer_next = adv_timer;
                     phase_idx_next   = adv_idx;
                  end
                  fright_timer_next = FRIGHT_T;
                  eat_count_next    = '0;
                  reverse_next      = 1'b1;
               end else begin
                  state_next       = adv_state;
                  phase_timer_next = adv_timer;
                  phase_idx_next   = adv_idx;
                  reverse_next     = period_end && (adv_state != state_reg);
               end
            end
            ST_FRIGHT: begin
               if (power_pellet) begin
                  fright_timer_next = FRIGHT_T;
                  eat_count_next    = '0;
               end else begin
                  if (ghost_eaten && eat_count_reg != 2'd3)
                     eat_count_next = eat_count_reg + 2'd1;
                  if (frame_tick) begin
                     fright_timer_next = fright_timer_reg - 12'd1;
                     if (fright_timer_reg == 12'd1) begin
                        state_next     = saved_reg;
                        eat_count_next = '0;
                     end
                  end
               end
            end
         endcase
      end
   end

`ifdef FRIGHT_FLASH_EN
   localparam logic [11:0] FLASH_T = 12'(FLASH_FRAMES);

   logic       flash_reg, flash_next;
   logic [2:0] flash_cnt_reg, flash_cnt_next;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         flash_reg     <= 1'b0;
         flash_cnt_reg <= '0;
      end else begin
         flash_reg     <= flash_next;
         flash_cnt_reg <= flash_cnt_next;
      end
   end

   // Window is judged on the next timer value so flash lines up with the registered mode.
   always_comb begin
      flash_next     = flash_reg;
      flash_cnt_next = flash_cnt_reg;
      if (state_next != ST_FRIGHT || fright_timer_next > FLASH_T) begin
         flash_next     = 1'b0;
         flash_cnt_next = '0;
      end else if (fright_timer_reg > FLASH_T) begin
         flash_next     = 1'b1;
         flash_cnt_next = '0;
      end else if (frame_tick) begin
         flash_cnt_next = flash_cnt_reg + 3'd1;
         if (flash_cnt_reg == 3'd7)
            flash_next = ~flash_reg;
      end
   end

   assign frightened_flash = flash_reg;
`else
   assign frightened_flash = 1'b0;
`endif

   assign mode          = state_reg;
   assign reverse_pulse = reverse_reg;
   assign eat_count     = eat_count_reg;
   assign phase_idx     = phase_idx_reg;

endmodule

// File: tb/tb_ghost_mode_scheduler.sv
// Directed bench for ghost_mode_scheduler with SCATTER=4, CHASE=6, FRIGHT=5, FLASH=2, NUM_PHASES=2.
module tb_ghost_mode_scheduler;

   logic       Clk = 1'b0;
   logic       Reset_n;
   logic       playon;
   logic       frame_tick;
   logic       power_pellet;
   logic       ghost_eaten;
   logic [1:0] mode;
   logic       reverse_pulse;
   logic       frightened_flash;
   logic [1:0] eat_count;
   logic [2:0] phase_idx;

   int checks = 0;
   int errors = 0;

`ifdef FRIGHT_FLASH_EN
   localparam logic FLASH_ON = 1'b1;
`else
   localparam logic FLASH_ON = 1'b0;
`endif

   ghost_mode_scheduler #(
      .SCATTER_FRAMES(4),
      .CHASE_FRAMES(6),
      .FRIGHT_FRAMES(5),
      .FLASH_FRAMES(2),
      .NUM_PHASES(2)
   ) dut (
      .Clk(Clk),
      .Reset_n(Reset_n),
      .playon(playon),
      .frame_tick(frame_tick),
      .power_pellet(power_pellet),
      .ghost_eaten(ghost_eaten),
      .mode(mode),
      .reverse_pulse(reverse_pulse),
      .frightened_flash(frightened_flash),
      .eat_count(eat_count),
      .phase_idx(phase_idx)
   );

   always #5 Clk = ~Clk;

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   // Drive one cycle of pulses, then sample 1 time unit after the edge.
   task automatic step(input logic t, input logic p, input logic g);
      frame_tick   = t;
      power_pellet = p;
      ghost_eaten  = g;
      @(posedge Clk);
      #1;
      frame_tick   = 1'b0;
      power_pellet = 1'b0;
      ghost_eaten  = 1'b0;
   endtask

   task automatic restart();
      playon = 1'b0;
      step(1'b0, 1'b0, 1'b0);
      playon = 1'b1;
      step(1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      Reset_n = 1'b0; playon = 1'b0; frame_tick = 1'b0; power_pellet = 1'b0; ghost_eaten = 1'b0;
      @(posedge Clk); #1;
      checks++; if ({mode, reverse_pulse, frightened_flash, eat_count, phase_idx} !== 9'd0) begin errors++; $display("FAIL reset_outputs got %b want 0", {mode, reverse_pulse, frightened_flash, eat_count, phase_idx}); end
      Reset_n = 1'b1; playon = 1'b1;
      step(1'b0, 1'b0, 1'b0);
      checks++; if (mode !== 2'b01 || phase_idx !== 3'd0 || reverse_pulse !== 1'b0) begin errors++; $display("FAIL first_scatter got mode=%b idx=%0d rev=%b want 01 0 0", mode, phase_idx, reverse_pulse); end
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
      checks++; if (mode !== 2'b10) begin errors++; $display("FAIL pre_reset_chase got %b want 10", mode); end
      #3 Reset_n = 1'b0;
      #1;
      checks++; if ({mode, reverse_pulse, eat_count, phase_idx} !== 8'd0) begin errors++; $display("FAIL async_reset got %b want 0", {mode, reverse_pulse, eat_count, phase_idx}); end
      Reset_n = 1'b1; playon = 1'b0;
      step(1'b0, 1'b0, 1'b0);
      checks++; if (mode !== 2'b00) begin errors++; $display("FAIL off_after_reset got %b want 00", mode); end
      playon = 1'b1;
      step(1'b0, 1'b0, 1'b0);
      checks++; if (mode !== 2'b01 || phase_idx !== 3'd0 || reverse_pulse !== 1'b0) begin errors++; $display("FAIL rearm_scatter got mode=%b idx=%0d rev=%b want 01 0 0", mode, phase_idx, reverse_pulse); end
      $display("test_reset done");
   endtask

   task automatic test_schedule();
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 1'b0);
         checks++; if (mode !== 2'b01) begin errors++; $display("FAIL scatter_hold tick%0d got %b want 01", i, mode); end
      end
      step(1'b1, 1'b0, 1'b0);
      checks++; if (mode !== 2'b10 || reverse_pulse !== 1'b1) begin errors++; $display("FAIL to_chase got mode=%b rev=%b want 10 1", mode, reverse_pulse); end
      step(1'b0, 1'b0, 1'b0);
      checks++; if (reverse_pulse !== 1'b0) begin errors++; $display("FAIL rev_one_cycle got %b want 0", reverse_pulse); end
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
      checks++; if (mode !== 2'b10 || phase_idx !== 3'd0) begin errors++; $display("FAIL chase_hold got mode=%b idx=%0d want 10 0", mode, phase_idx); end
      step(1'b1, 1'b0, 1'b0);
      checks++; if (mode !== 2'b01 || phase_idx !== 3'd1 || reverse_pulse !== 1'b1) begin errors++; $display("FAIL to_scatter1 got mode=%b idx=%0d rev=%b want 01 1 1", mode, phase_idx, reverse_pulse); end
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
      checks++; if (mode !== 2'b10 || reverse_pulse !== 1'b1) begin errors++; $display("FAIL to_chase1 got mode=%b rev=%b want 10 1", mode, reverse_pulse); end
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0);
      checks++; if (mode !== 2'b10 || reverse_pulse !== 1'b0 || phase_idx !== 3'd1) begin errors++; $display("FAIL final_chase_end got mode=%b rev=%b idx=%0d want 10 0 1", mode, reverse_pulse, phase_idx); end
      for (int i = 0; i < 50; i++) begin
         step(1'b1, 1'b0, 1'b0);
         checks++; if (mode !== 2'b10 || reverse_pulse !== 1'b0 || phase_idx !== 3'd1) begin errors++; $display("FAIL perm_chase tick%0d got mode=%b rev=%b idx=%0d want 10 0 1", i, mode, reverse_pulse, phase_idx); end
      end
      $display("test_schedule done");
   endtask

   task automatic test_fright();
      restart();
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      checks++; if (mode !== 2'b11 || reverse_pulse !== 1'b1 || frightened_flash !== 1'b0) begin errors++; $display("FAIL enter_fright got mode=%b rev=%b flash=%b want 11 1 0", mode, reverse_pulse, frightened_flash); end
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
      checks++; if (mode !== 2'b11 || frightened_flash !== FLASH_ON) begin errors++; $display("FAIL flash_window got mode=%b flash=%b want 11 %b", mode, frightened_flash, FLASH_ON); end
      step(1'b1, 1'b0, 1'b0);
      checks++; if (mode !== 2'b11 || frightened_flash !== FLASH_ON) begin errors++; $display("FAIL fright_last got mode=%b flash=%b want 11 %b", mode, frightened_flash, FLASH_ON); end
      step(1'b1, 1'b0, 1'b0);
      checks++; if (mode !== 2'b01 || reverse_pulse !== 1'b0 || frightened_flash !== 1'b0) begin errors++; $display("FAIL fright_exit got mode=%b rev=%b flash=%b want 01 0 0", mode, reverse_pulse, frightened_flash); end
      step(1'b1, 1'b0, 1'b0);
      checks++; if (mode !== 2'b01) begin errors++; $display("FAIL resume_hold got %b want 01", mode); end
      step(1'b1, 1'b0, 1'b0);
      checks++; if (mode !== 2'b10 || reverse_pulse !== 1'b1) begin errors++; $display("FAIL resume_to_chase got mode=%b rev=%b want 10 1", mode, reverse_pulse); end
      $display("test_fright done");
   endtask

   task automatic test_reload_and_eat();
      logic [1:0] exp_eat [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      restart();
      step(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b0, 1'b1);
         checks++; if (eat_count !== exp_eat[i]) begin errors++; $display("FAIL eat_count[%0d] got %0d want %0d", i, eat_count, exp_eat[i]); end
      end
      step(1'b0, 1'b1, 1'b0);
      checks++; if (mode !== 2'b11 || eat_count !== 2'd0 || reverse_pulse !== 1'b0 || frightened_flash !== 1'b0) begin errors++; $display("FAIL reload got mode=%b eat=%0d rev=%b flash=%b want 11 0 0 0", mode, eat_count, reverse_pulse, frightened_flash); end
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
      checks++; if (mode !== 2'b11) begin errors++; $display("FAIL reload_hold got %b want 11", mode); end
      step(1'b1, 1'b0, 1'b0);
      checks++; if (mode !== 2'b01 || reverse_pulse !== 1'b0 || eat_count !== 2'd0) begin errors++; $display("FAIL reload_exit got mode=%b rev=%b eat=%0d want 01 0 0", mode, reverse_pulse, eat_count); end
      $display("test_reload_and_eat done");
   endtask

   task automatic test_simultaneous();
      restart();
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      checks++; if (mode !== 2'b11 || reverse_pulse !== 1'b1 || phase_idx !== 3'd0) begin errors++; $display("FAIL coincide_enter got mode=%b rev=%b idx=%0d want 11 1 0", mode, reverse_pulse, phase_idx); end
      step(1'b0, 1'b0, 1'b0);
      checks++; if (reverse_pulse !== 1'b0) begin errors++; $display("FAIL coincide_single_rev got %b want 0", reverse_pulse); end
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
      checks++; if (mode !== 2'b10 || reverse_pulse !== 1'b0) begin errors++; $display("FAIL coincide_exit got mode=%b rev=%b want 10 0", mode, reverse_pulse); end
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
      checks++; if (mode !== 2'b10) begin errors++; $display("FAIL full_chase_hold got %b want 10", mode); end
      step(1'b1, 1'b0, 1'b0);
      checks++; if (mode !== 2'b01 || phase_idx !== 3'd1 || reverse_pulse !== 1'b1) begin errors++; $display("FAIL full_chase_end got mode=%b idx=%0d rev=%b want 01 1 1", mode, phase_idx, reverse_pulse); end
      $display("test_simultaneous done");
   endtask

   task automatic test_playon_drop();
      restart();
      step(1'b0, 1'b0, 1'b1);
      checks++; if (eat_count !== 2'd0) begin errors++; $display("FAIL eat_outside_fright got %0d want 0", eat_count); end
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      checks++; if (eat_count !== 2'd1) begin errors++; $display("FAIL eat_once got %0d want 1", eat_count); end
      step(1'b0, 1'b1, 1'b1);
      checks++; if (eat_count !== 2'd0) begin errors++; $display("FAIL pellet_beats_eat got %0d want 0", eat_count); end
      step(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
      checks++; if (frightened_flash !== FLASH_ON || mode !== 2'b11) begin errors++; $display("FAIL drop_pre_flash got mode=%b flash=%b want 11 %b", mode, frightened_flash, FLASH_ON); end
      playon = 1'b0;
      step(1'b0, 1'b0, 1'b0);
      checks++; if ({mode, reverse_pulse, frightened_flash, eat_count, phase_idx} !== 9'd0) begin errors++; $display("FAIL playon_drop got %b want 0", {mode, reverse_pulse, frightened_flash, eat_count, phase_idx}); end
      $display("test_playon_drop done");
   endtask

   initial begin
      test_reset();
      test_schedule();
      test_fright();
      test_reload_and_eat();
      test_simultaneous();
      test_playon_drop();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
